// File: rtl/serial_word_packer_pkg.sv
// Shared types and constants for the serial word packer.
package serial_packer_pkg;

  typedef enum logic {
    COLLECT    = 1'b0,
    FLUSH_WAIT = 1'b1
  } packer_state_e;

  localparam int PACKER_FIFO_DEPTH = 2;
  localparam int PACKER_WCNT_W     = 16;

endpackage

// File: rtl/serial_word_packer_if.sv
// Handshake bundle between the packer and its bit source / word consumer.
interface serial_word_packer_if #(
  parameter int WIDTH = 8
);
  logic             clr;
  logic             bit_in;
  logic             bit_valid;
  logic             bit_ready;
  logic             flush;
  logic [WIDTH-1:0] word_out;
  logic             word_valid;
  logic             word_ready;
  logic             busy;

  modport master (
    output clr, bit_in, bit_valid, flush, word_ready,
    input  bit_ready, word_out, word_valid, busy
  );

  modport slave (
    input  clr, bit_in, bit_valid, flush, word_ready,
    output bit_ready, word_out, word_valid, busy
  );
endinterface

// File: rtl/serial_word_packer_fifo2.sv
// Two-entry output buffer; push and pop may coincide even when full.
module packer_fifo2
  import serial_packer_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] head_o,
  output logic [1:0]       count_o
);
  logic [WIDTH-1:0] mem0_q, mem0_d, mem1_q, mem1_d;
  logic [1:0]       count_q, count_d;
  logic             pop_ok, push_ok;

  always_comb begin
    mem0_d  = mem0_q;
    mem1_d  = mem1_q;
    count_d = count_q;
    pop_ok  = pop_i && (count_q != 2'd0);
    push_ok = push_i && ((count_q < 2'(PACKER_FIFO_DEPTH)) || pop_ok);
    case ({push_ok, pop_ok})
      2'b10: begin
        if (count_q == 2'd0) mem0_d = din_i;
        else                 mem1_d = din_i;
        count_d = count_q + 2'd1;
      end
      2'b01: begin
        mem0_d  = mem1_q;
        count_d = count_q - 2'd1;
      end
      2'b11: begin
        // Count unchanged; the new word slots in behind the survivor.
        if (count_q == 2'd1) begin
          mem0_d = din_i;
        end else begin
          mem0_d = mem1_q;
          mem1_d = din_i;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem0_q  <= '0;
      mem1_q  <= '0;
      count_q <= 2'd0;
    end else if (clr) begin
      mem0_q  <= '0;
      mem1_q  <= '0;
      count_q <= 2'd0;
    end else begin
      mem0_q  <= mem0_d;
      mem1_q  <= mem1_d;
      count_q <= count_d;
    end
  end

  assign head_o  = mem0_q;
  assign count_o = count_q;
endmodule

// File: rtl/serial_word_packer.sv
// Packs an MSB-first serial bit stream into WIDTH-bit words with flush/clear.
// Optional word counter output enabled by SERIAL_PACKER_WORDCNT_EN.
module serial_word_packer
  import serial_packer_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input logic clk,
  input logic rst,
  serial_word_packer_if.slave pif
`ifdef SERIAL_PACKER_WORDCNT_EN
  , output logic [PACKER_WCNT_W-1:0] word_count
`endif
);
  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  packer_state_e    state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d, acc_shift, pad_word, push_word;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       fifo_count;
  logic             ready, accept, push, pop, wvalid;

  assign ready     = (state_q == COLLECT) &&
                     ((cnt_q != LAST) || (fifo_count < 2'(PACKER_FIFO_DEPTH)));
  assign wvalid    = (fifo_count != 2'd0);
  assign accept    = pif.bit_valid && ready;
  assign pop       = wvalid && pif.word_ready;
  assign acc_shift = {acc_q[WIDTH-2:0], pif.bit_in};
  // Only the low cnt_q bits of acc_q are live; the shift discards stale upper bits.
  assign pad_word  = acc_q << (WIDTH - int'(cnt_q));

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    push      = 1'b0;
    push_word = acc_shift;
    case (state_q)
      COLLECT: begin
        if (accept) begin
          acc_d = acc_shift;
          if (cnt_q == LAST) begin
            push  = 1'b1;
            cnt_d = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        if (pif.flush && (cnt_d != '0)) state_d = FLUSH_WAIT;
      end
      FLUSH_WAIT: begin
        if ((fifo_count < 2'(PACKER_FIFO_DEPTH)) || pop) begin
          push      = 1'b1;
          push_word = pad_word;
          cnt_d     = '0;
          state_d   = COLLECT;
        end
      end
      default: state_d = COLLECT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= COLLECT;
      acc_q   <= '0;
      cnt_q   <= '0;
    end else if (pif.clr) begin
      state_q <= COLLECT;
      acc_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
    end
  end

  packer_fifo2 #(.WIDTH(WIDTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .clr     (pif.clr),
    .push_i  (push),
    .pop_i   (pop),
    .din_i   (push_word),
    .head_o  (pif.word_out),
    .count_o (fifo_count)
  );

  assign pif.bit_ready  = ready;
  assign pif.word_valid = wvalid;
  assign pif.busy       = (cnt_q != '0) || (state_q == FLUSH_WAIT) || wvalid;

`ifdef SERIAL_PACKER_WORDCNT_EN
  logic [PACKER_WCNT_W-1:0] wcnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                    wcnt_q <= '0;
    else if (pif.clr)                           wcnt_q <= '0;
    else if (push && (wcnt_q != '1))            wcnt_q <= wcnt_q + 1'b1;
  end

  assign word_count = wcnt_q;
`endif
endmodule
